// File: rtl/dma_reader.sv
// dma_reader: AXI3 read master that streams a contiguous block of 64-bit DDR words through an FWFT FIFO.
// Latency: arvalid rises two cycles after enable_i rises; a beat reaches data_o one cycle after its R handshake.
// Backpressure: a burst is requested only once the FIFO has unreserved room for all of it, so rready never stalls.
//
// Ports:
//   aclk, rst_n                      clock, asynchronous active-low reset
//   enable_i, base_addr_i,
//   num_beats_i                      run control: rising edge of enable_i in IDLE starts a run
//   m_axi_ar*                        AXI3 read-address channel (INCR, 8-byte beats)
//   m_axi_r*                         AXI3 read-data channel
//   data_o, data_valid_o,
//   data_ready_i                     FWFT word stream to the consumer
//   finished_o, dma_engaged_o,
//   error_o                          run status; error_o is sticky for the run

module dma_reader_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head word is read combinationally: first-word-fall-through.
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

module dma_reader #(
  parameter int BURST_LEN      = 16,
  parameter int FIFO_DEPTH     = 32,
  parameter int BEAT_CNT_WIDTH = 20
) (
  input  logic                      aclk,
  input  logic                      rst_n,
  input  logic                      enable_i,
  input  logic [31:0]               base_addr_i,
  input  logic [BEAT_CNT_WIDTH-1:0] num_beats_i,
  output logic [31:0]               m_axi_araddr,
  output logic [3:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [63:0]               m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [63:0]               data_o,
  output logic                      data_valid_o,
  input  logic                      data_ready_i,
  output logic                      finished_o,
  output logic                      dma_engaged_o,
  output logic                      error_o
);
  localparam int LW = $clog2(BURST_LEN + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = BEAT_CNT_WIDTH;

  typedef enum logic [2:0] {
    IDLE, WAIT_SPACE, ADDR, DATA, DRAIN, DONE
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          en_q;
  logic          start;
  logic [31:0]   addr;
  logic [BW-1:0] remaining;
  logic [LW-1:0] len;
  logic [LW-1:0] beats;
  logic [CW-1:0] reserved;
  logic [LW-1:0] burst;
  logic [CW-1:0] avail;
  logic          space_ok;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [63:0]   head;

  assign m_axi_arsize  = 3'd3;
  assign m_axi_arburst = 2'b01;
  assign m_axi_rready  = (state == DATA);
  assign dma_engaged_o = (state == WAIT_SPACE) || (state == ADDR) ||
                         (state == DATA) || (state == DRAIN);

  assign start    = enable_i & ~en_q;
  assign burst    = (remaining < BW'(BURST_LEN)) ? LW'(remaining) : LW'(BURST_LEN);
  // Room that is neither occupied nor promised to the burst in flight.
  assign avail    = CW'(FIFO_DEPTH) - fifo_count - reserved;
  assign space_ok = (avail >= CW'(burst));

  dma_reader_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (aclk),
    .rst_n (rst_n),
    .push  (m_axi_rready & m_axi_rvalid),
    .wdata (m_axi_rdata),
    .pop   (data_ready_i),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign data_valid_o = ~fifo_empty;
  // Memory contents are not reset; keep the output at zero while nothing is held.
  assign data_o       = fifo_empty ? 64'd0 : head;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (start) next_state = (num_beats_i == '0) ? DONE : WAIT_SPACE;
      WAIT_SPACE: if (space_ok) next_state = ADDR;
      ADDR:       if (m_axi_arready) next_state = DATA;
      // remaining was already reduced at the AR handshake.
      DATA:       if (m_axi_rvalid && m_axi_rlast)
                    next_state = (remaining != '0) ? WAIT_SPACE : DRAIN;
      DRAIN:      if (fifo_empty) next_state = DONE;
      DONE:       if (!enable_i) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      en_q          <= 1'b0;
      finished_o    <= 1'b0;
      error_o       <= 1'b0;
      addr          <= '0;
      remaining     <= '0;
      len           <= '0;
      beats         <= '0;
      reserved      <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
    end else begin
      en_q       <= enable_i;
      finished_o <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr_i;
            remaining <= num_beats_i;
            error_o   <= 1'b0;
            reserved  <= '0;
          end
        end
        WAIT_SPACE: begin
          if (space_ok) begin
            m_axi_araddr  <= addr;
            m_axi_arlen   <= 4'(burst - LW'(1));
            m_axi_arvalid <= 1'b1;
            len           <= burst;
            beats         <= '0;
            reserved      <= reserved + CW'(burst);
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            addr          <= addr + (32'(len) << 3);
            remaining     <= remaining - BW'(len);
          end
        end
        DATA: begin
          if (m_axi_rvalid) begin
            if (m_axi_rresp != 2'b00) error_o <= 1'b1;
            // A beat arriving after the issued length was already consumed.
            if (beats == len) error_o <= 1'b1;
            if (m_axi_rlast) begin
              if (beats + LW'(1) != len) error_o <= 1'b1;
              // Hand back this beat's slot plus any a short burst never used.
              reserved <= reserved - CW'(len - beats);
            end else if (beats != len) begin
              reserved <= reserved - CW'(1);
              beats    <= beats + LW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_reader.sv
module tb_dma_reader;
  logic        aclk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic [31:0] base_addr_i;
  logic [19:0] num_beats_i;
  logic [31:0] m_axi_araddr;
  logic [3:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [63:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i;
  logic        finished_o;
  logic        dma_engaged_o;
  logic        error_o;

  dma_reader dut (
    .aclk(aclk), .rst_n(rst_n), .enable_i(enable_i), .base_addr_i(base_addr_i),
    .num_beats_i(num_beats_i), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .finished_o(finished_o), .dma_engaged_o(dma_engaged_o), .error_o(error_o)
  );

  always #5 aclk = ~aclk;

  int vecs = 0;
  int errs = 0;
  logic [63:0] exp_words[$];
  logic [35:0] exp_bursts[$];   // {araddr, arlen}
  logic [35:0] r_q[$];          // bursts accepted by the slave, awaiting data
  int r_beat = 0;
  int total_beats = 0;
  int bursts_seen = 0;
  int words_seen = 0;
  int err_beat = -1;
  int ar_mode = 0;              // 0: arready always 1, 1: random
  int r_mode = 0;               // 0: rvalid whenever data pending, 1: random gaps
  int rdy_mode = 1;             // 0: never, 1: always, 2: random
  logic [31:0] seed;

  function automatic logic [63:0] word_at(input logic [31:0] a);
    return {a ^ seed, a + ~seed};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave model: AR/R responder; all changes at negedge, effects committed for the next posedge.
  initial begin
    logic        ar_hold;
    logic [31:0] hold_addr;
    logic [3:0]  hold_len;
    logic        r_fired;
    logic [35:0] b;
    logic [35:0] e;
    ar_hold = 0; hold_addr = 0; hold_len = 0; r_fired = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    forever begin
      @(negedge aclk);
      if (!rst_n) begin
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
        ar_hold = 0; r_fired = 0; r_beat = 0;
        continue;
      end
      // R channel: a presented beat is held until it is taken.
      if (!(m_axi_rvalid && !r_fired)) begin
        if (r_q.size() > 0 && (r_mode == 0 || $urandom_range(0, 2) != 0)) begin
          b = r_q[0];
          m_axi_rvalid = 1;
          m_axi_rdata  = word_at(b[35:4] + 32'(8 * r_beat));
          m_axi_rlast  = (r_beat == int'(b[3:0]));
          m_axi_rresp  = (total_beats == err_beat) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
        end
      end
      r_fired = m_axi_rvalid && m_axi_rready;
      if (r_fired) begin
        total_beats++;
        if (m_axi_rlast) begin
          void'(r_q.pop_front());
          r_beat = 0;
        end else r_beat++;
      end
      // AR channel.
      if (ar_hold)
        chk("ar_stable", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, {1'b1, hold_addr, hold_len});
      m_axi_arready = (ar_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (m_axi_arvalid && m_axi_arready) begin
        e = 'x;
        if (exp_bursts.size() > 0) e = exp_bursts.pop_front();
        chk("ar_burst", {m_axi_araddr, m_axi_arlen}, e);
        r_q.push_back({m_axi_araddr, m_axi_arlen});
        bursts_seen++;
        ar_hold = 0;
      end else begin
        ar_hold = m_axi_arvalid;
        hold_addr = m_axi_araddr;
        hold_len = m_axi_arlen;
      end
    end
  end

  // Consumer: pops data and compares against the expected word stream.
  initial begin
    logic [63:0] e;
    data_ready_i = 0;
    forever begin
      @(negedge aclk);
      if (!rst_n) begin
        data_ready_i = 0;
        continue;
      end
      data_ready_i = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (data_valid_o && data_ready_i) begin
        e = 'x;
        if (exp_words.size() > 0) e = exp_words.pop_front();
        chk("data_word", data_o, e);
        words_seen++;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic start_run(input logic [31:0] base, input int n);
    int l;
    exp_words.delete();
    exp_bursts.delete();
    for (int i = 0; i < n; i++) exp_words.push_back(word_at(base + 32'(8 * i)));
    for (int i = 0; i < n; i += 16) begin
      l = (n - i < 16) ? n - i : 16;
      exp_bursts.push_back({base + 32'(8 * i), 4'(l - 1)});
    end
    total_beats = 0; bursts_seen = 0; words_seen = 0;
    base_addr_i = base;
    num_beats_i = 20'(n);
    enable_i = 1;
  endtask

  task automatic wait_finish(input int budget);
    for (int k = 0; k < budget && !finished_o; k++) cyc(1);
    chk("finish_in_time", finished_o, 1);
  endtask

  task automatic check_run_end(input int n);
    chk("engaged_after", dma_engaged_o, 0);
    chk("words_count", 64'(words_seen), 64'(n));
    chk("words_left", 64'(exp_words.size()), 0);
    chk("bursts_left", 64'(exp_bursts.size()), 0);
  endtask

  task automatic end_run;
    enable_i = 0;
    cyc(3);
    chk("finished_clear", finished_o, 0);
  endtask

  task automatic check_reset_outputs;
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", m_axi_arlen, 0);
    chk("rst_arsize", m_axi_arsize, 3);
    chk("rst_arburst", m_axi_arburst, 1);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_data", data_o, 0);
    chk("rst_valid", data_valid_o, 0);
    chk("rst_finished", finished_o, 0);
    chk("rst_engaged", dma_engaged_o, 0);
    chk("rst_error", error_o, 0);
  endtask

  task automatic full_run(input logic [31:0] base, input int n);
    start_run(base, n);
    wait_finish(3000);
    check_run_end(n);
    end_run();
  endtask

  initial begin
    int seen_arv;
    int n;
    seed = $urandom;
    rst_n = 0; enable_i = 0; base_addr_i = 0; num_beats_i = 0;
    cyc(3);
    check_reset_outputs();
    rst_n = 1;
    cyc(2);

    // 1: basic run with start latency, then enable held high must not restart.
    ar_mode = 0; r_mode = 0; rdy_mode = 1;
    start_run(32'h1000_0000, 40);
    cyc(1);
    chk("lat_n1_arvalid", m_axi_arvalid, 0);
    chk("lat_n1_engaged", dma_engaged_o, 1);
    cyc(1);
    chk("lat_n2_arvalid", m_axi_arvalid, 1);
    chk("lat_n2_araddr", m_axi_araddr, 32'h1000_0000);
    chk("lat_n2_arlen", m_axi_arlen, 15);
    wait_finish(1000);
    check_run_end(40);
    chk("basic_bursts", 64'(bursts_seen), 3);
    seen_arv = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (m_axi_arvalid) seen_arv++;
    end
    chk("no_restart_arvalid", 64'(seen_arv), 0);
    chk("no_restart_finished", finished_o, 1);
    end_run();

    // 2: consumer stalled, FIFO fills with two bursts, then released.
    rdy_mode = 0;
    start_run($urandom & 32'hFFFF_FF80, 64);
    cyc(200);
    chk("bp_bursts", 64'(bursts_seen), 2);
    chk("bp_beats", 64'(total_beats), 32);
    chk("bp_arvalid", m_axi_arvalid, 0);
    chk("bp_valid", data_valid_o, 1);
    chk("bp_engaged", dma_engaged_o, 1);
    rdy_mode = 1;
    wait_finish(2000);
    check_run_end(64);
    chk("bp_bursts_total", 64'(bursts_seen), 4);
    end_run();

    // 3: zero length.
    start_run(32'h0000_4000, 0);
    cyc(1);
    chk("zero_fin_n1", finished_o, 0);
    cyc(1);
    chk("zero_fin_n2", finished_o, 1);
    chk("zero_engaged", dma_engaged_o, 0);
    cyc(5);
    chk("zero_no_ar", 64'(bursts_seen), 0);
    end_run();

    // 4: error response on beat 5, sticky, cleared by the next start.
    err_beat = 4;
    start_run(32'h0800_0100, 16);
    wait_finish(1000);
    check_run_end(16);
    chk("err_set", error_o, 1);
    end_run();
    chk("err_sticky_idle", error_o, 1);
    err_beat = -1;
    start_run(32'h0800_0400, 8);
    cyc(1);
    chk("err_cleared", error_o, 0);
    wait_finish(1000);
    check_run_end(8);
    chk("err_still_clear", error_o, 0);
    end_run();

    // 5: random stalls, enable dropped mid-run.
    ar_mode = 1; r_mode = 1; rdy_mode = 2;
    start_run(32'h2000_0F80, 17);
    cyc(10);
    enable_i = 0;
    wait_finish(3000);
    check_run_end(17);
    chk("stall_bursts", 64'(bursts_seen), 2);
    end_run();

    // Address wrap across 2^32.
    ar_mode = 0; r_mode = 0; rdy_mode = 1;
    full_run(32'hFFFF_FF80, 24);

    // Random runs.
    for (int r = 0; r < 5; r++) begin
      ar_mode = int'($urandom_range(0, 1));
      r_mode = int'($urandom_range(0, 1));
      rdy_mode = int'($urandom_range(1, 2));
      n = int'($urandom_range(1, 70));
      full_run($urandom & 32'hFFFF_FF80, n);
    end

    // 6: reset during beat 3 of a burst, then a clean restart.
    ar_mode = 0; r_mode = 0; rdy_mode = 1;
    start_run(32'h3000_0000, 40);
    for (int k = 0; k < 200 && total_beats < 2; k++) cyc(1);
    chk("rst_beat3_reached", 64'(total_beats), 2);
    #4;
    rst_n = 0;
    enable_i = 0;
    #1;
    check_reset_outputs();
    exp_words.delete();
    exp_bursts.delete();
    r_q.delete();
    cyc(2);
    chk("rst_fifo_empty", data_valid_o, 0);
    chk("rst_rready_hold", m_axi_rready, 0);
    rst_n = 1;
    cyc(2);
    full_run(32'h3000_0000, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/dma_reader.md
Name: dma_reader

Overview:
- AXI3 read master on the PS HP0 port. It is the playback counterpart to the DDR-writing dma_controller.
- It fetches a contiguous block of 64-bit words from DDR in INCR bursts and buffers them in an internal first-word-fall-through (FWFT) FIFO.
- It presents the words to pdh_core as a valid/ready stream, e.g. for DAC waveform playback.
- It runs in the fclk0 domain and drives the HP0 AR/R channels, which are currently tied off.

Parameters:
- BURST_LEN, 16, max beats per burst (1..16, AXI3 arlen limit)
- FIFO_DEPTH, 32, FIFO entries; power of two, at least BURST_LEN
- BEAT_CNT_WIDTH, 20, width of the beat-count input

Ports:
- aclk  in  1  fclk0 clock
- rst_n  in  1  asynchronous active-low reset
- enable_i  in  1  level; rising edge seen in IDLE starts a run
- base_addr_i  in  32  start byte address; must be 128-byte aligned
- num_beats_i  in  BEAT_CNT_WIDTH  number of 64-bit words to read
- m_axi_araddr  out  32  burst address
- m_axi_arlen  out  4  beats-1
- m_axi_arsize  out  3  constant 3'd3 (8 bytes)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arvalid  out  1  address valid
- m_axi_arready  in  1  address accepted
- m_axi_rdata  in  64  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat of burst
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data accept
- data_o  out  64  FIFO head word
- data_valid_o  out  1  FIFO non-empty
- data_ready_i  in  1  consumer pop
- finished_o  out  1  run complete, FIFO drained
- dma_engaged_o  out  1  run in progress
- error_o  out  1  sticky: any rresp != OKAY seen this run

Behaviour:

Reset:
- All outputs are 0, except m_axi_arsize=3 and m_axi_arburst=1, which are constant.
- FIFO empty, state IDLE, counters cleared.
- Reset asserted mid-burst abandons the transfer immediately; no further R beats are accepted.

States:
- IDLE:
  - On a rising edge of enable_i (registered compare), latch base_addr_i and num_beats_i and clear error_o.
  - If num_beats_i=0, go to DONE. Otherwise go to WAIT_SPACE.
- WAIT_SPACE:
  - Let len = min(remaining, BURST_LEN).
  - When free entries minus reserved entries is at least len: reserve len, drive araddr and arlen=len-1, assert arvalid, and go to ADDR.
- ADDR:
  - Hold araddr, arlen and arvalid stable until arready.
  - On the handshake: deassert arvalid next cycle, add 8*len to addr, subtract len from remaining, and go to DATA.
- DATA:
  - m_axi_rready=1. Every rvalid beat is written to the FIFO and releases one reservation.
  - If rresp!=0, set error_o; the data is still stored.
  - On the beat with rlast: if remaining>0, go to WAIT_SPACE; else go to DRAIN.
  - An rlast whose beat count differs from len sets error_o; the counters follow the issued len.
- DRAIN: when the FIFO is empty, go to DONE.
- DONE:
  - finished_o=1. Stay until enable_i=0, then go to IDLE with finished_o=0.

Outputs and timing:
- dma_engaged_o=1 in WAIT_SPACE, ADDR, DATA and DRAIN.
- One burst outstanding at a time; no read interleaving.
- Latency: enable_i rises in cycle N. The edge is detected in N+1; arvalid is first asserted in cycle N+2 when the FIFO has space.

Enable handling:
- enable_i falling mid-run is ignored; the run completes.
- enable_i held high through DONE does not restart a run; a new rising edge is required.

FIFO:
- FWFT: data_o and data_valid_o reflect the head word.
- Pop occurs when data_valid_o & data_ready_i.
- A simultaneous push and pop when full is impossible, since space is reserved before the AR handshake.
- A simultaneous push and pop in any other state is legal and leaves the count unchanged.
- A write beat lands at the head 1 cycle after the R handshake.

Address rules:
- Bursts never cross a 4 KB boundary, which follows from the 128-byte alignment and BURST_LEN<=16.
- Address arithmetic is 32-bit and wraps modulo 2^32 with no special handling.
- A partial final burst uses arlen=remaining-1.

Test Plan:
1. Basic run: base=0x1000_0000, num_beats=40, arready/rvalid always 1, data_ready_i=1. Expect three bursts at 0x1000_0000 (arlen 15), 0x1000_0080 (arlen 15) and 0x1000_0100 (arlen 7). data_o carries 40 words in order, then finished_o=1 and dma_engaged_o=0.
2. Backpressure: data_ready_i=0 with num_beats=64 and FIFO_DEPTH=32. Expect exactly two bursts issued, a third arvalid not asserted, and FIFO full (32). Release data_ready_i: the remaining two bursts follow, 64 words total, no loss or duplication.
3. Zero length: num_beats=0 and enable rises. Expect no arvalid ever; finished_o=1 two cycles after the edge. Then enable=0 returns to IDLE with finished_o=0.
4. Error response: return rresp=2'b10 on beat 5 of a 16-beat run. Expect error_o=1 sticky, all 16 words delivered, finished_o=1. error_o clears on the next start.
5. Stalls: random arready/rvalid gaps with num_beats=17. Expect araddr/arlen held stable while arvalid && !arready, and bursts of arlen 15 then arlen 0 at +0x80.
6. Reset mid-DATA: drop rst_n during beat 3 of a burst. Expect all outputs at reset values asynchronously, FIFO empty, and a fresh enable edge to restart cleanly from base.
